// File: rtl/prbs_mon_pkg.sv
// Shared state encodings for the PRBS lock monitor.
package prbs_mon_pkg;

  typedef logic [1:0] prbs_state_t;

  localparam prbs_state_t ST_IDLE    = 2'b00;
  localparam prbs_state_t ST_ACQUIRE = 2'b01;
  localparam prbs_state_t ST_LOCKED  = 2'b10;
  localparam prbs_state_t ST_LOST    = 2'b11;

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with a synchronous clear that has priority over increment.
module prbs_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic sat;

  assign sat = &count;

  // Count up on inc, hold at all-ones, clear wins over everything.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_lock_monitor.sv
// Lock/error monitor downstream of the parallel PRBS checker.
module prbs_lock_monitor
  import prbs_mon_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 256,
  parameter int unsigned ERR_WIN    = 64,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             prbs_en_i,
  input  logic             chk_error_i,
  input  logic             clear_i,
  output logic             prbs_lock_o,
  output logic             prbs_err_sticky_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [1:0]       state_o
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT) + 1;
  localparam int unsigned WIN_W = $clog2(ERR_WIN) + 1;
  localparam int unsigned WE_W  = $clog2(ERR_THRESH) + 1;

  prbs_state_t      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WE_W-1:0]  werr_q, werr_d;
  logic             lock_q;
  logic             sticky_q;
  logic             err_locked;

  assign err_locked = prbs_en_i && (state_q == ST_LOCKED) && chk_error_i;

  // Next state plus clean-run, window and window-error counters.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    werr_d  = werr_q;
    if (!prbs_en_i) begin
      state_d = ST_IDLE;
      run_d   = '0;
      win_d   = '0;
      werr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          run_d   = '0;
          win_d   = '0;
          werr_d  = '0;
        end
        ST_ACQUIRE: begin
          if (chk_error_i) begin
            run_d = '0;
          end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Threshold check comes first so a threshold hit on the last window
          // cycle still drops lock instead of being wiped by the wrap.
          if (chk_error_i && (werr_q == WE_W'(ERR_THRESH - 1))) begin
            state_d = ST_LOST;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_W'(ERR_WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            if (chk_error_i) begin
              werr_d = werr_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          run_d   = '0;
          win_d   = '0;
          werr_d  = '0;
        end
      endcase
    end
  end

  // State, counter and registered lock-flag update.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      lock_q  <= (state_d == ST_LOCKED);
    end
  end

  // Sticky error: set by a locked-state error or by passing through LOST.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sticky_q <= 1'b0;
    end else if (clear_i) begin
      sticky_q <= 1'b0;
    end else if (err_locked || (prbs_en_i && (state_q == ST_LOST))) begin
      sticky_q <= 1'b1;
    end
  end

  prbs_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .inc     (err_locked),
    .clr     (clear_i),
    .count   (err_count_o)
  );

  assign state_o           = state_q;
  assign prbs_lock_o       = lock_q;
  assign prbs_err_sticky_o = sticky_q;

endmodule
